// File: rtl/reg_bank_sb.sv
// Register file with two combinational read ports, one write-back port, optional zero register,
// write-to-read bypass and a per-register busy scoreboard for RAW hazard detection.
module reg_bank_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] rb1,
    output logic [DATA_W-1:0] ar1,
    output logic [DATA_W-1:0] br1,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] wd,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic [ADDR_W:0]   n_busy
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   n_busy_q, n_busy_d;
    logic              wr_ok, alloc_ok, byp_ok;

    assign wr_ok    = we && !((ZERO_REG != 0) && (rw == '0));
    assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
    // Bypass is gated during reset so the read ports show the cleared state.
    assign byp_ok   = (BYPASS != 0) && !rst && we;

    // Allocate is applied after the write-back clear so a new producer wins a collision.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[rw] = 1'b0;
        end
        if (alloc_ok) begin
            busy_d[alloc_addr] = 1'b1;
        end
        n_busy_d = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            n_busy_d = n_busy_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q   <= '0;
            n_busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[rw] <= wd;
            end
            busy_q   <= busy_d;
            n_busy_q <= n_busy_d;
        end
    end

    assign n_busy = n_busy_q;

    always_comb begin
        ar1    = regs_q[ra1];
        busy_a = busy_q[ra1];
        if (byp_ok && (rw == ra1)) begin
            ar1    = wd;
            busy_a = 1'b0;
        end
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            ar1    = '0;
            busy_a = 1'b0;
        end
    end

    always_comb begin
        br1    = regs_q[rb1];
        busy_b = busy_q[rb1];
        if (byp_ok && (rw == rb1)) begin
            br1    = wd;
            busy_b = 1'b0;
        end
        if ((ZERO_REG != 0) && (rb1 == '0)) begin
            br1    = '0;
            busy_b = 1'b0;
        end
    end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register file for the pipelined datapath: two combinational read ports, one write-back port with enable, optional hard-wired zero register, and write-to-read bypass. It also keeps a per-register busy scoreboard, set when decode allocates a destination and cleared on write-back, so decode can detect RAW hazards. It sits between decode (read and allocate) and the write-back stage (write and clear).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 5, register address width; depth NREGS = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and allocations, is never busy
- BYPASS, 1, 1: same-cycle write-back data and busy-clear forward to the read ports

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- ra1  in  ADDR_W  read address, port A
- rb1  in  ADDR_W  read address, port B
- ar1  out  DATA_W  read data, port A (combinational)
- br1  out  DATA_W  read data, port B (combinational)
- busy_a  out  1  register at ra1 has an outstanding producer
- busy_b  out  1  register at rb1 has an outstanding producer
- we  in  1  write-back enable
- rw  in  ADDR_W  write-back address
- wd  in  DATA_W  write-back data
- alloc_en  in  1  mark alloc_addr busy
- alloc_addr  in  ADDR_W  destination register being allocated
- n_busy  out  ADDR_W+1  registered count of busy registers

## Operation
- Reset (rst high, asynchronous): all registers clear to 0, all busy bits clear, n_busy = 0. While rst is high, writes and allocations are ignored and bypass is gated off, so ar1 = br1 = 0, busy_a = busy_b = 0.
- Write: on a rising edge with we = 1, reg[rw] <= wd and busy[rw] clears. With ZERO_REG = 1 and rw = 0, nothing changes.
- Allocate: on a rising edge with alloc_en = 1, busy[alloc_addr] sets. Ignored for address 0 when ZERO_REG = 1. Allocating an already busy register leaves it busy, with no double count.
- Simultaneous write-back clear and allocate to the same register: allocate wins, busy stays 1 (new producer), data is still written.
- Read port A (port B identical with rb1/br1/busy_b):
  - ZERO_REG = 1 and ra1 = 0: ar1 = 0, busy_a = 0.
  - BYPASS = 1, we = 1, rw = ra1: ar1 = wd and busy_a = 0. The write-back covers the pending producer unless allocate hits the same address this cycle; busy_a reflects state before the edge.
  - Otherwise: ar1 = reg[ra1], busy_a = busy[ra1].
- BYPASS = 0: reads return only the stored array and busy vector; a same-cycle write is visible from the next cycle.
- n_busy equals popcount of the busy vector after each edge. Range 0..NREGS (NREGS-1 when ZERO_REG = 1). It never wraps.

## Timing
- Read latency 0 (combinational from ra1/rb1, and from we/rw/wd when BYPASS = 1).
- Write and allocate take effect at the rising edge. Array and busy outputs reflect them from the next cycle.
- n_busy updates at the same edge as the busy vector: one-cycle register, no extra lag.
- Reset asserted mid-operation aborts any same-cycle write or allocate. After deassertion, the first rising edge behaves normally.
- No handshake. Write-back and allocate are single-cycle strobes and are accepted every cycle.

## Test plan
- Reset: write 0xBEEF to r3, assert rst asynchronously mid-cycle -> ar1 (ra1 = 3) = 0 immediately; after release, ar1 = 0, n_busy = 0.
- Write/read: we = 1, rw = 5, wd = 0x1234, BYPASS = 1, ra1 = 5 -> ar1 = 0x1234 in the same cycle. With BYPASS = 0 -> old value in that cycle, 0x1234 the next.
- Zero register: we = 1, rw = 0, wd = 0xFFFF, then alloc_en with alloc_addr = 0 -> ar1 (ra1 = 0) = 0, busy_a = 0, n_busy unchanged.
- Scoreboard: allocate r7 -> busy_a (ra1 = 7) = 1, n_busy = 1. Write-back r7 -> busy_a = 0 same cycle (bypass) and after the edge; n_busy = 0.
- Collision: r9 busy; same cycle we = 1 rw = 9 wd = 0x00AA and alloc_en alloc_addr = 9 -> next cycle reg = 0x00AA, busy = 1, n_busy = 1.
- Count: allocate all registers 1..31 over 31 cycles, re-allocate r4 -> n_busy = 31, no overflow. Clear all -> n_busy = 0.
